// File: rtl/ab_conditioner.sv
// Two-channel synchronizer and debouncer for a/b level inputs.
// Optional macro EDGE_PULSE_EN adds registered rising-edge pulses a_rise/b_rise.
module ab_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic a_raw,
   input  logic b_raw,
   output logic a_out,
   output logic b_out
`ifdef EDGE_PULSE_EN
   ,
   output logic a_rise,
   output logic b_rise
`endif
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic [1:0] raw_w;
   logic [1:0] out_w;
`ifdef EDGE_PULSE_EN
   logic [1:0] rise_w;
`endif

   assign raw_w = {b_raw, a_raw};

   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_w;
      logic [CW-1:0]          cnt_q;
      logic [CW-1:0]          cnt_d;
      logic                   out_q;
      logic                   out_d;
      logic                   ld_w;

      assign sync_w = sync_q[SYNC_STAGES-1];

      // Debounce: count stable mismatching cycles, load out when count is full.
      always_comb begin
         cnt_d = cnt_q;
         out_d = out_q;
         ld_w  = 1'b0;
         if (sync_w == out_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_MAX) begin
            ld_w  = 1'b1;
            out_d = sync_w;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Synchronizer chain, debounce counter and output level register.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_w[c]};
            cnt_q  <= cnt_d;
            out_q  <= out_d;
         end
      end

      assign out_w[c] = out_q;

`ifdef EDGE_PULSE_EN
      logic rise_q;

      // Pulse in the first cycle out reads 1 after a 0->1 load.
      always_ff @(posedge clk) begin
         if (rst) begin
            rise_q <= 1'b0;
         end else begin
            rise_q <= ld_w & sync_w;
         end
      end

      assign rise_w[c] = rise_q;
`endif
   end

   assign a_out = out_w[0];
   assign b_out = out_w[1];
`ifdef EDGE_PULSE_EN
   assign a_rise = rise_w[0];
   assign b_rise = rise_w[1];
`endif

endmodule

// File: tb/tb_ab_conditioner.sv
// Directed, table-driven bench for ab_conditioner.
// Second instance covers SYNC_STAGES=3, DB_CYCLES=1.
module tb_ab_conditioner;

   logic clk;
   logic rst;
   logic a_raw;
   logic b_raw;
   logic a_out;
   logic b_out;
   logic a1_out;
   logic b1_out;
`ifdef EDGE_PULSE_EN
   logic a_rise;
   logic b_rise;
   logic a1_rise;
   logic b1_rise;
`endif

   int total;
   int bad;

   typedef struct {
      logic rst;
      logic a;
      logic b;
      logic ea;
      logic eb;
   } vec_t;

   vec_t tv[$];

   ab_conditioner #(
      .SYNC_STAGES(2),
      .DB_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .a_raw(a_raw),
      .b_raw(b_raw),
      .a_out(a_out),
      .b_out(b_out)
`ifdef EDGE_PULSE_EN
      ,
      .a_rise(a_rise),
      .b_rise(b_rise)
`endif
   );

   ab_conditioner #(
      .SYNC_STAGES(3),
      .DB_CYCLES(1)
   ) dut1 (
      .clk(clk),
      .rst(rst),
      .a_raw(a_raw),
      .b_raw(b_raw),
      .a_out(a1_out),
      .b_out(b1_out)
`ifdef EDGE_PULSE_EN
      ,
      .a_rise(a1_rise),
      .b_rise(b1_rise)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input int n, input logic r, input logic a,
                      input logic b, input logic ea, input logic eb);
      vec_t v;
      v.rst = r;
      v.a   = a;
      v.b   = b;
      v.ea  = ea;
      v.eb  = eb;
      for (int k = 0; k < n; k++) tv.push_back(v);
   endtask

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic a, input logic b);
      rst   = r;
      a_raw = a;
      b_raw = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic pa;
      logic pb;
      logic pbo;
      int   rcnt;
      int   fcnt;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      a_raw = 1'b0;
      b_raw = 1'b0;

      // reset with raw high, then both rise together at edge 6
      add(2, 1, 1, 1, 0, 0);
      add(5, 0, 1, 1, 0, 0);
      add(3, 0, 1, 1, 1, 1);
      // simultaneous fall
      add(5, 0, 0, 0, 1, 1);
      add(3, 0, 0, 0, 0, 0);
      // steady step on A only
      add(5, 0, 1, 0, 0, 0);
      add(3, 0, 1, 0, 1, 0);
      add(5, 0, 0, 0, 1, 0);
      add(3, 0, 0, 0, 0, 0);
      // 3-cycle glitch, then a step must still need 6 edges
      add(3, 0, 1, 0, 0, 0);
      add(8, 0, 0, 0, 0, 0);
      add(5, 0, 1, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0);
      add(5, 0, 0, 0, 1, 0);
      add(3, 0, 0, 0, 0, 0);
      // bounce 1,0,1,0 then hold 1
      add(1, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0);
      add(5, 0, 1, 0, 0, 0);
      add(2, 0, 1, 0, 1, 0);
      add(5, 0, 0, 0, 1, 0);
      add(3, 0, 0, 0, 0, 0);
      // mid-debounce reset at edge 4
      add(3, 0, 1, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0);
      add(5, 0, 1, 0, 0, 0);
      add(2, 0, 1, 0, 1, 0);
      // reset while out is high clears it
      add(1, 1, 1, 1, 0, 0);

      pa = 1'b0;
      pb = 1'b0;
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].rst, tv[i].a, tv[i].b);
         chk($sformatf("v%0d a_out", i), a_out, tv[i].ea);
         chk($sformatf("v%0d b_out", i), b_out, tv[i].eb);
`ifdef EDGE_PULSE_EN
         chk($sformatf("v%0d a_rise", i), a_rise, tv[i].ea & ~pa);
         chk($sformatf("v%0d b_rise", i), b_rise, tv[i].eb & ~pb);
`endif
         pa = tv[i].ea;
         pb = tv[i].eb;
      end

`ifdef EDGE_PULSE_EN
      // b: 0->1 held 10, 1->0 held 10; one pulse coincident with first b_out=1
      step(1, 0, 0);
      step(1, 0, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 0);
      rcnt = 0;
      fcnt = 0;
      pbo  = b_out;
      for (int k = 0; k < 10; k++) begin
         step(0, 0, 1);
         if (b_rise) begin
            rcnt++;
            chk("pulse b_out now 1", b_out, 1'b1);
            chk("pulse b_out was 0", pbo, 1'b0);
         end
         pbo = b_out;
      end
      chk("b_out high after 10", b_out, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step(0, 0, 0);
         if (b_rise) fcnt++;
      end
      chk("b_out low after 10", b_out, 1'b0);
      total++;
      if (rcnt != 1) begin
         bad++;
         $display("FAIL rise count: got %0d want 1", rcnt);
      end
      total++;
      if (fcnt != 0) begin
         bad++;
         $display("FAIL fall pulses: got %0d want 0", fcnt);
      end
`endif

      // DB_CYCLES=1, SYNC_STAGES=3 instance: latency 4, follows sync
      step(1, 0, 0);
      step(1, 0, 0);
      for (int k = 0; k < 5; k++) step(0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         step(0, 1, 0);
         chk($sformatf("db1 a edge%0d", k), a1_out, 1'b0);
      end
      step(0, 1, 0);
      chk("db1 a edge4", a1_out, 1'b1);
      step(0, 1, 1);
      chk("db1 b glitch e1", b1_out, 1'b0);
      step(0, 1, 0);
      chk("db1 b glitch e2", b1_out, 1'b0);
      step(0, 1, 0);
      chk("db1 b glitch e3", b1_out, 1'b0);
      step(0, 1, 0);
      chk("db1 b glitch e4", b1_out, 1'b1);
      step(0, 1, 0);
      chk("db1 b glitch e5", b1_out, 1'b0);
      chk("db1 a held", a1_out, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
